// File: rtl/pcie_write_desc_sched_pkg.sv
// Shared definitions for the PCIe DMA write descriptor scheduler.
//  - Default configuration values used by the top-level parameters.
//  - idx_width(): index width helper that never returns 0, so a
//    single-entry configuration still gets a 1-bit index.
// The slot-table entry layout {port, req_tag} is declared in the top module,
// because its field widths follow the top-level parameters.
package pcie_write_desc_sched_pkg;

   localparam int DEF_PORT_COUNT      = 4;
   localparam int DEF_PCIE_ADDR_WIDTH = 64;
   localparam int DEF_RAM_ADDR_WIDTH  = 15;
   localparam int DEF_LEN_WIDTH       = 16;
   localparam int DEF_REQ_TAG_WIDTH   = 8;
   localparam int DEF_SLOT_COUNT      = 16;
   localparam int DEF_PORT_MAX_OUT    = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pcie_write_desc_sched_rr_arbiter.sv
// Round-robin arbiter. Combinational only.
//  req       : request vector, one bit per requester
//  ptr       : highest-priority requester this cycle
//  grant     : one-hot grant (zero when no request)
//  grant_idx : index of the granted requester
//  grant_vld : any grant
// The first requester found at or after ptr, wrapping, wins.
module pcie_write_desc_sched_rr_arbiter
   import pcie_write_desc_sched_pkg::*;
#(
   parameter int N = DEF_PORT_COUNT,
   parameter int W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_vld
);

   int         cand;
   logic [W-1:0] cidx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = 0;
      cidx      = '0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr) + i) % N;
         cidx = W'(cand);
         if (!grant_vld && req[cidx]) begin
            grant_vld   = 1'b1;
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/pcie_write_desc_sched.sv
// PCIe DMA write descriptor scheduler.
// Shares one descriptor port to the PCIe DMA write engine between PORT_COUNT
// requesters with round-robin arbitration. Every issued descriptor takes the
// lowest free slot ID as its DMA tag; the slot remembers {port, req tag} so the
// completion can be routed back to its owner with the original tag.
// Ports:
//  pcie_clk, pcie_rst         clock, synchronous active-high reset
//  s_desc_*                   per-port requests (packed, port 0 in the LSBs)
//  s_desc_ready               per-port accept, one-hot or zero, combinational
//  s_status_valid/_tag        one-cycle completion pulse to the owning port
//  m_desc_*                   registered descriptor to the DMA engine
//  m_status_valid/_tag        completion from the DMA engine (slot ID)
//  slots_free                 free slot count (registered state)
//  status_err                 pulse: completion for a slot that was not busy
module pcie_write_desc_sched
   import pcie_write_desc_sched_pkg::*;
#(
   parameter int PORT_COUNT      = DEF_PORT_COUNT,
   parameter int PORT_WIDTH      = idx_width(PORT_COUNT),
   parameter int PCIE_ADDR_WIDTH = DEF_PCIE_ADDR_WIDTH,
   parameter int RAM_ADDR_WIDTH  = DEF_RAM_ADDR_WIDTH,
   parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
   parameter int REQ_TAG_WIDTH   = DEF_REQ_TAG_WIDTH,
   parameter int SLOT_COUNT      = DEF_SLOT_COUNT,
   parameter int SLOT_WIDTH      = idx_width(SLOT_COUNT),
   parameter int PORT_MAX_OUT    = DEF_PORT_MAX_OUT
) (
   input  logic                                  pcie_clk,
   input  logic                                  pcie_rst,
   input  logic [PORT_COUNT*PCIE_ADDR_WIDTH-1:0] s_desc_pcie_addr,
   input  logic [PORT_COUNT*RAM_ADDR_WIDTH-1:0]  s_desc_ram_addr,
   input  logic [PORT_COUNT*LEN_WIDTH-1:0]       s_desc_len,
   input  logic [PORT_COUNT*REQ_TAG_WIDTH-1:0]   s_desc_tag,
   input  logic [PORT_COUNT-1:0]                 s_desc_valid,
   output logic [PORT_COUNT-1:0]                 s_desc_ready,
   output logic [REQ_TAG_WIDTH-1:0]              s_status_tag,
   output logic [PORT_COUNT-1:0]                 s_status_valid,
   output logic [PCIE_ADDR_WIDTH-1:0]            m_desc_pcie_addr,
   output logic [RAM_ADDR_WIDTH-1:0]             m_desc_ram_addr,
   output logic [LEN_WIDTH-1:0]                  m_desc_len,
   output logic [SLOT_WIDTH-1:0]                 m_desc_tag,
   output logic                                  m_desc_valid,
   input  logic                                  m_desc_ready,
   input  logic [SLOT_WIDTH-1:0]                 m_status_tag,
   input  logic                                  m_status_valid,
   output logic [SLOT_WIDTH:0]                   slots_free,
   output logic                                  status_err
);

   localparam int CNT_W = $clog2(PORT_MAX_OUT + 1);

   typedef struct packed {
      logic [PORT_WIDTH-1:0]    port;
      logic [REQ_TAG_WIDTH-1:0] tag;
   } slot_ent_t;

   // per-port views of the packed request buses
   logic [PORT_COUNT-1:0][PCIE_ADDR_WIDTH-1:0] req_pcie_addr;
   logic [PORT_COUNT-1:0][RAM_ADDR_WIDTH-1:0]  req_ram_addr;
   logic [PORT_COUNT-1:0][LEN_WIDTH-1:0]       req_len;
   logic [PORT_COUNT-1:0][REQ_TAG_WIDTH-1:0]   req_tag;

   assign req_pcie_addr = s_desc_pcie_addr;
   assign req_ram_addr  = s_desc_ram_addr;
   assign req_len       = s_desc_len;
   assign req_tag       = s_desc_tag;

   logic [SLOT_COUNT-1:0]                 slot_busy;
   slot_ent_t [SLOT_COUNT-1:0]            slot_ent;
   logic [PORT_COUNT-1:0][CNT_W-1:0]      out_cnt;
   logic [PORT_WIDTH-1:0]                 rr_ptr;

   logic                  free_any;
   logic [SLOT_WIDTH-1:0] free_idx;
   logic [PORT_COUNT-1:0] port_elig, grant, cnt_inc, st_oh;
   logic [PORT_WIDTH-1:0] grant_idx;
   logic                  grant_vld, out_ok, accept;
   logic                  st_hit, st_err;
   slot_ent_t             st_ent;

   // lowest-index free slot: scan downwards so the last hit is the lowest
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
         if (!slot_busy[SLOT_WIDTH'(i)]) begin
            free_any = 1'b1;
            free_idx = SLOT_WIDTH'(i);
         end
      end
   end

   assign st_ent = slot_ent[m_status_tag];
   assign st_hit = m_status_valid &&  slot_busy[m_status_tag];
   assign st_err = m_status_valid && !slot_busy[m_status_tag];

   always_comb begin
      port_elig = '0;
      cnt_inc   = '0;
      st_oh     = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         port_elig[PORT_WIDTH'(p)] = s_desc_valid[PORT_WIDTH'(p)] && free_any &&
                                     (out_cnt[PORT_WIDTH'(p)] < CNT_W'(PORT_MAX_OUT));
         cnt_inc[PORT_WIDTH'(p)]   = accept && (grant_idx == PORT_WIDTH'(p));
         st_oh[PORT_WIDTH'(p)]     = st_hit && (st_ent.port == PORT_WIDTH'(p));
      end
   end

   pcie_write_desc_sched_rr_arbiter #(
      .N (PORT_COUNT),
      .W (PORT_WIDTH)
   ) u_arb (
      .req       (port_elig),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // the output register can take a new descriptor when empty or draining;
   // ready is masked in reset so no requester sees a phantom accept
   assign out_ok       = (!m_desc_valid || m_desc_ready) && !pcie_rst;
   assign accept       = grant_vld && out_ok;
   assign s_desc_ready = grant & {PORT_COUNT{out_ok}};

   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         slot_busy        <= '0;
         slot_ent         <= '0;
         out_cnt          <= '0;
         rr_ptr           <= '0;
         m_desc_valid     <= 1'b0;
         m_desc_pcie_addr <= '0;
         m_desc_ram_addr  <= '0;
         m_desc_len       <= '0;
         m_desc_tag       <= '0;
         s_status_valid   <= '0;
         s_status_tag     <= '0;
         status_err       <= 1'b0;
         slots_free       <= (SLOT_WIDTH+1)'(SLOT_COUNT);
      end else begin
         if (accept) begin
            slot_busy[free_idx] <= 1'b1;
            slot_ent[free_idx]  <= slot_ent_t'{port: grant_idx, tag: req_tag[grant_idx]};
            m_desc_valid        <= 1'b1;
            m_desc_pcie_addr    <= req_pcie_addr[grant_idx];
            m_desc_ram_addr     <= req_ram_addr[grant_idx];
            m_desc_len          <= req_len[grant_idx];
            m_desc_tag          <= free_idx;
            rr_ptr              <= (grant_idx == PORT_WIDTH'(PORT_COUNT - 1)) ?
                                   '0 : grant_idx + 1'b1;
         end else if (m_desc_ready) begin
            m_desc_valid <= 1'b0;
         end

         // freed slot is never the one being allocated: allocation only
         // picks slots that are free in the registered state
         if (st_hit) begin
            slot_busy[m_status_tag] <= 1'b0;
            s_status_tag            <= st_ent.tag;
         end
         s_status_valid <= st_oh;
         status_err     <= st_err;

         slots_free <= slots_free - (SLOT_WIDTH+1)'(accept) + (SLOT_WIDTH+1)'(st_hit);

         for (int p = 0; p < PORT_COUNT; p++) begin
            if (cnt_inc[PORT_WIDTH'(p)] && !st_oh[PORT_WIDTH'(p)])
               out_cnt[PORT_WIDTH'(p)] <= out_cnt[PORT_WIDTH'(p)] + 1'b1;
            else if (st_oh[PORT_WIDTH'(p)] && !cnt_inc[PORT_WIDTH'(p)])
               out_cnt[PORT_WIDTH'(p)] <= out_cnt[PORT_WIDTH'(p)] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_write_desc_sched.sv
// Bench for pcie_write_desc_sched (default parameters).
// Stimulus drives per-cycle directed vectors and pushes the expected
// descriptors / completions into queues; a negedge monitor pops and compares
// whenever the DUT presents a descriptor handshake, a status pulse or an error.
module tb_pcie_write_desc_sched;

   logic          pcie_clk = 1'b0;
   logic          pcie_rst = 1'b1;
   logic [255:0]  s_desc_pcie_addr;
   logic [59:0]   s_desc_ram_addr;
   logic [63:0]   s_desc_len;
   logic [31:0]   s_desc_tag;
   logic [3:0]    s_desc_valid;
   logic [3:0]    s_desc_ready;
   logic [7:0]    s_status_tag;
   logic [3:0]    s_status_valid;
   logic [63:0]   m_desc_pcie_addr;
   logic [14:0]   m_desc_ram_addr;
   logic [15:0]   m_desc_len;
   logic [3:0]    m_desc_tag;
   logic          m_desc_valid;
   logic          m_desc_ready;
   logic [3:0]    m_status_tag;
   logic          m_status_valid;
   logic [4:0]    slots_free;
   logic          status_err;

   pcie_write_desc_sched dut (
      .pcie_clk         (pcie_clk),
      .pcie_rst         (pcie_rst),
      .s_desc_pcie_addr (s_desc_pcie_addr),
      .s_desc_ram_addr  (s_desc_ram_addr),
      .s_desc_len       (s_desc_len),
      .s_desc_tag       (s_desc_tag),
      .s_desc_valid     (s_desc_valid),
      .s_desc_ready     (s_desc_ready),
      .s_status_tag     (s_status_tag),
      .s_status_valid   (s_status_valid),
      .m_desc_pcie_addr (m_desc_pcie_addr),
      .m_desc_ram_addr  (m_desc_ram_addr),
      .m_desc_len       (m_desc_len),
      .m_desc_tag       (m_desc_tag),
      .m_desc_valid     (m_desc_valid),
      .m_desc_ready     (m_desc_ready),
      .m_status_tag     (m_status_tag),
      .m_status_valid   (m_status_valid),
      .slots_free       (slots_free),
      .status_err       (status_err)
   );

   always #5 pcie_clk = ~pcie_clk;

   typedef struct {
      logic [63:0] a;
      logic [14:0] r;
      logic [15:0] l;
      logic [3:0]  s;
   } desc_t;
   typedef struct {
      logic [3:0] oh;
      logic [7:0] t;
   } stat_t;

   desc_t desc_q[$];
   stat_t stat_q[$];
   bit    err_q[$];

   int tests = 0;
   int fails = 0;

   logic [7:0] ptag [4];
   logic [3:0] pv;

   // request fields are a fixed function of port and requester tag
   function automatic logic [63:0] f_addr(input int p, input logic [7:0] t);
      return {32'hA000_0000 + 32'(p), 24'h0, t};
   endfunction
   function automatic logic [14:0] f_ram(input int p, input logic [7:0] t);
      return {2'(p), 5'h0, t};
   endfunction
   function automatic logic [15:0] f_len(input int p, input logic [7:0] t);
      return {4'h1, 2'(p), 2'b00, t};
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < 4; p++) begin
         s_desc_pcie_addr[p*64 +: 64] = f_addr(p, ptag[p]);
         s_desc_ram_addr[p*15 +: 15]  = f_ram(p, ptag[p]);
         s_desc_len[p*16 +: 16]       = f_len(p, ptag[p]);
         s_desc_tag[p*8 +: 8]         = ptag[p];
      end
      s_desc_valid = pv;
   endtask

   // one clock: check ready, predict the accepted descriptor, advance accepted tags
   task automatic cyc(input logic [3:0] exp_rdy, input int slot);
      #1;
      chk("s_desc_ready", 64'(s_desc_ready), 64'(exp_rdy));
      for (int p = 0; p < 4; p++)
         if (exp_rdy[p])
            desc_q.push_back('{f_addr(p, ptag[p]), f_ram(p, ptag[p]), f_len(p, ptag[p]), 4'(slot)});
      @(posedge pcie_clk);
      #1;
      for (int p = 0; p < 4; p++)
         if (exp_rdy[p]) ptag[p] = ptag[p] + 8'd1;
      m_status_valid = 1'b0;
      drive();
   endtask

   task automatic stat_in(input int slot, input logic [3:0] oh, input logic [7:0] t, input bit err);
      m_status_valid = 1'b1;
      m_status_tag   = 4'(slot);
      if (err) err_q.push_back(1'b1);
      else     stat_q.push_back('{oh, t});
   endtask

   task automatic do_reset(input bit chk_q);
      if (chk_q) begin
         chk("desc_q_drained", 64'(desc_q.size()), 0);
         chk("stat_q_drained", 64'(stat_q.size()), 0);
         chk("err_q_drained",  64'(err_q.size()), 0);
      end
      desc_q.delete();
      stat_q.delete();
      err_q.delete();
      pv             = '0;
      m_status_valid = 1'b0;
      m_status_tag   = '0;
      m_desc_ready   = 1'b1;
      drive();
      pcie_rst = 1'b1;
      repeat (2) @(posedge pcie_clk);
      #1 pcie_rst = 1'b0;
      chk("rst_m_desc_valid",   64'(m_desc_valid), 0);
      chk("rst_s_status_valid", 64'(s_status_valid), 0);
      chk("rst_status_err",     64'(status_err), 0);
      chk("rst_slots_free",     64'(slots_free), 16);
   endtask

   // scoreboard monitor
   always @(negedge pcie_clk) begin
      if (!pcie_rst) begin
         if (m_desc_valid && m_desc_ready) begin
            tests++;
            if (desc_q.size() == 0) begin
               fails++;
               $display("FAIL desc_unexpected: got tag %0h addr %0h, none expected", m_desc_tag, m_desc_pcie_addr);
            end else begin
               desc_t e;
               e = desc_q.pop_front();
               if (m_desc_pcie_addr !== e.a || m_desc_ram_addr !== e.r ||
                   m_desc_len !== e.l || m_desc_tag !== e.s) begin
                  fails++;
                  $display("FAIL desc: got tag %0h addr %0h ram %0h len %0h expected tag %0h addr %0h ram %0h len %0h",
                           m_desc_tag, m_desc_pcie_addr, m_desc_ram_addr, m_desc_len, e.s, e.a, e.r, e.l);
               end
            end
         end
         if (s_status_valid != 4'b0) begin
            tests++;
            if (stat_q.size() == 0) begin
               fails++;
               $display("FAIL status_unexpected: got port %b tag %0h, none expected", s_status_valid, s_status_tag);
            end else begin
               stat_t e;
               e = stat_q.pop_front();
               if (s_status_valid !== e.oh || s_status_tag !== e.t) begin
                  fails++;
                  $display("FAIL status: got port %b tag %0h expected port %b tag %0h",
                           s_status_valid, s_status_tag, e.oh, e.t);
               end
            end
         end
         if (status_err) begin
            tests++;
            if (err_q.size() == 0) begin
               fails++;
               $display("FAIL status_err: got 1 expected 0");
            end else begin
               void'(err_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int p = 0; p < 4; p++) ptag[p] = '0;
      pv = '0;
      m_status_valid = 1'b0;
      m_status_tag   = '0;
      m_desc_ready   = 1'b1;
      drive();

      // 1: single request and completion
      do_reset(1'b0);
      ptag[0] = 8'h11; pv = 4'b0001; drive();
      cyc(4'b0001, 0);
      pv = '0; drive();
      chk("t1_slots_free_after_issue", 64'(slots_free), 15);
      stat_in(0, 4'b0001, 8'h11, 1'b0);
      cyc(4'b0000, 0);
      chk("t1_slots_free_after_status", 64'(slots_free), 16);
      cyc(4'b0000, 0);

      // 2: all ports, round-robin, fill every slot
      do_reset(1'b1);
      ptag[0] = 8'h40; ptag[1] = 8'h50; ptag[2] = 8'h60; ptag[3] = 8'h70;
      pv = 4'hF; drive();
      for (int i = 0; i < 16; i++) cyc(4'(1 << (i % 4)), i);
      cyc(4'b0000, 0);
      chk("t2_slots_free_full", 64'(slots_free), 0);
      pv = '0; drive();
      cyc(4'b0000, 0);

      // 3: per-port outstanding limit
      do_reset(1'b1);
      ptag[1] = 8'h30; ptag[2] = 8'h50; pv = 4'b0010; drive();
      for (int i = 0; i < 8; i++) cyc(4'b0010, i);
      cyc(4'b0000, 0);
      pv = 4'b0110; drive();
      cyc(4'b0100, 8);
      pv = 4'b0010; drive();
      stat_in(3, 4'b0010, 8'h33, 1'b0);
      cyc(4'b0000, 0);
      cyc(4'b0010, 3);
      pv = '0; drive();
      cyc(4'b0000, 0);

      // 4: out-of-order completions, freed slots reused lowest first
      do_reset(1'b1);
      ptag[0] = 8'h60; ptag[1] = 8'h70; ptag[2] = 8'h80; ptag[3] = 8'h90;
      pv = 4'hF; drive();
      for (int i = 0; i < 12; i++) cyc(4'(1 << (i % 4)), i);
      pv = '0; drive();
      stat_in(5, 4'b0010, 8'h71, 1'b0); cyc(4'b0000, 0);
      stat_in(2, 4'b0100, 8'h80, 1'b0); cyc(4'b0000, 0);
      stat_in(9, 4'b0010, 8'h72, 1'b0); cyc(4'b0000, 0);
      ptag[3] = 8'hA0; pv = 4'b1000; drive();
      cyc(4'b1000, 2);
      cyc(4'b1000, 5);
      pv = '0; drive();
      cyc(4'b0000, 0);

      // 5: accept + status in the same cycle, then status to a free slot
      do_reset(1'b1);
      ptag[0] = 8'h90; ptag[1] = 8'hA0; ptag[2] = 8'hB0; ptag[3] = 8'hC0;
      pv = 4'hF; drive();
      for (int i = 0; i < 15; i++) cyc(4'(1 << (i % 4)), i);
      stat_in(4, 4'b0001, 8'h91, 1'b0);
      cyc(4'b1000, 15);
      chk("t5_slots_free_same_cycle", 64'(slots_free), 1);
      cyc(4'b0001, 4);
      cyc(4'b0000, 0);
      chk("t5_slots_free_full", 64'(slots_free), 0);
      pv = '0; drive();
      stat_in(3, 4'b1000, 8'hC0, 1'b0); cyc(4'b0000, 0);
      stat_in(3, 4'b0000, 8'h00, 1'b1); cyc(4'b0000, 0);
      cyc(4'b0000, 0);
      chk("t5_slots_free_after_err", 64'(slots_free), 1);

      // 6: downstream stall, then reset in the middle of it
      do_reset(1'b1);
      m_desc_ready = 1'b0;
      ptag[0] = 8'hD0; ptag[1] = 8'hE0; pv = 4'b0011; drive();
      cyc(4'b0001, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(4'b0000, 0);
         chk("t6_stall_valid", 64'(m_desc_valid), 1);
         chk("t6_stall_tag",   64'(m_desc_tag), 0);
         chk("t6_stall_addr",  m_desc_pcie_addr, f_addr(0, 8'hD0));
      end
      pcie_rst = 1'b1;
      #1;
      chk("t6_rst_ready", 64'(s_desc_ready), 0);
      @(posedge pcie_clk);
      #1;
      chk("t6_rst_m_desc_valid",   64'(m_desc_valid), 0);
      chk("t6_rst_m_desc_addr",    m_desc_pcie_addr, 0);
      chk("t6_rst_slots_free",     64'(slots_free), 16);
      chk("t6_rst_s_status_valid", 64'(s_status_valid), 0);
      chk("t6_rst_status_err",     64'(status_err), 0);
      pcie_rst = 1'b0;
      desc_q.delete();
      m_desc_ready = 1'b1;
      cyc(4'b0001, 0);
      pv = '0; drive();
      cyc(4'b0000, 0);

      chk("end_desc_q_drained", 64'(desc_q.size()), 0);
      chk("end_stat_q_drained", 64'(stat_q.size()), 0);
      chk("end_err_q_drained",  64'(err_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
